// File: rtl/mu_sweep_seq.sv
// Wishbone-configured delay-line sweep sequencer with a {code,hits} result FIFO.
// Optional build macro MU_SWEEP_IRQ_EN adds irq_o (done rising / FIFO reaching full).
module mu_sweep_seq #(
    parameter int FIFO_LG = 4,
    parameter int CMP_DLY = 4,
    parameter int CODE_W  = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_stall_o,
    output logic              wb_err_o,
    output logic [CODE_W-1:0] delay_code_o,
    output logic              stb_o,
    input  logic              cmp_i,
    output logic              busy_o
`ifdef MU_SWEEP_IRQ_EN
    ,
    output logic              irq_o
`endif
);
    localparam logic [FIFO_LG:0] FIFO_DEPTH = (FIFO_LG + 1)'(1 << FIFO_LG);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_STROBE, S_CAPTURE, S_PUSH, S_NEXT} state_t;
    state_t state;

    logic [CODE_W-1:0] start_r, stop_r, step_r, code;
    logic [15:0]       samples_r, settle_r, hits, left, wcnt;
    logic              done, start_req, abort_req, cmp_s1, cmp_s2, irq_bit;

    logic [CODE_W+15:0] mem [0:(1 << FIFO_LG)-1];
    logic [FIFO_LG-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LG:0]   fifo_cnt;
    logic               fifo_full, fifo_empty, push, pop, flush;

    // A request is accepted on any cycle with cyc&stb and no ack pending; the
    // registered ack follows exactly one cycle later and masks the held request.
    logic       wb_acc, wr, rd;
    logic [2:0] adr;
    logic [31:0] rd_data;
    logic [CODE_W-1:0] step_eff;
    logic [15:0]       samples_eff;
    logic [CODE_W:0]   sum;
    logic              unused_ok;

    assign wb_acc      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr          = wb_acc & wb_we_i;
    assign rd          = wb_acc & ~wb_we_i;
    assign adr         = wb_adr_i[4:2];
    assign wb_stall_o  = 1'b0;
    assign wb_err_o    = 1'b0;
    assign unused_ok   = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16]};

    assign fifo_full   = (fifo_cnt == FIFO_DEPTH);
    assign fifo_empty  = (fifo_cnt == '0);
    assign push        = (state == S_PUSH) && !fifo_full;
    assign pop         = rd && (adr == 3'd6) && !fifo_empty;
    assign flush       = (state == S_IDLE) && start_req && !abort_req;

    assign step_eff    = (step_r == '0) ? CODE_W'(1) : step_r;
    assign samples_eff = (samples_r == 16'd0) ? 16'd1 : samples_r;
    assign sum         = {1'b0, code} + {1'b0, step_eff};

    assign busy_o       = (state != S_IDLE);
    assign delay_code_o = code;

    always_comb begin
        rd_data = '0;
        case (adr)
            3'd0: rd_data = {27'd0, irq_bit, fifo_full, fifo_empty, done, busy_o};
            3'd1: rd_data = 32'(start_r);
            3'd2: rd_data = 32'(stop_r);
            3'd3: rd_data = 32'(step_r);
            3'd4: rd_data = 32'(samples_r);
            3'd5: rd_data = 32'(settle_r);
            3'd6: begin
                if (!fifo_empty) begin
                    rd_data[31]            = 1'b1;
                    rd_data[16 +: CODE_W]  = mem[rd_ptr][16 +: CODE_W];
                    rd_data[15:0]          = mem[rd_ptr][15:0];
                end
            end
            default: rd_data = 32'(fifo_cnt);
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            start_req <= 1'b0;
            abort_req <= 1'b0;
            start_r   <= '0;
            stop_r    <= '1;
            step_r    <= CODE_W'(1);
            samples_r <= 16'd1;
            settle_r  <= 16'd0;
        end else begin
            wb_ack_o  <= wb_acc;
            wb_dat_o  <= rd ? rd_data : '0;
            start_req <= wr && (adr == 3'd0) && wb_dat_i[0];
            abort_req <= wr && (adr == 3'd0) && wb_dat_i[1];
            if (wr) begin
                case (adr)
                    3'd1: start_r   <= wb_dat_i[CODE_W-1:0];
                    3'd2: stop_r    <= wb_dat_i[CODE_W-1:0];
                    3'd3: step_r    <= wb_dat_i[CODE_W-1:0];
                    3'd4: samples_r <= wb_dat_i[15:0];
                    3'd5: settle_r  <= wb_dat_i[15:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= {code, hits};
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state  <= S_IDLE;
            code   <= '0;
            hits   <= '0;
            left   <= '0;
            wcnt   <= '0;
            done   <= 1'b0;
            stb_o  <= 1'b0;
            cmp_s1 <= 1'b0;
            cmp_s2 <= 1'b0;
        end else begin
            cmp_s1 <= cmp_i;
            cmp_s2 <= cmp_s1;
            stb_o  <= 1'b0;
            if (abort_req && state != S_IDLE) begin
                state <= S_IDLE;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start_req && !abort_req) begin
                        code  <= start_r;
                        hits  <= '0;
                        left  <= samples_eff;
                        wcnt  <= '0;
                        done  <= 1'b0;
                        state <= S_SETTLE;
                    end
                    S_SETTLE: if (wcnt >= settle_r) begin
                        wcnt  <= '0;
                        stb_o <= 1'b1;
                        state <= S_STROBE;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                    S_STROBE: begin
                        wcnt  <= '0;
                        state <= S_CAPTURE;
                    end
                    S_CAPTURE: if (wcnt == 16'(CMP_DLY - 1)) begin
                        wcnt <= '0;
                        hits <= hits + {15'd0, cmp_s2};
                        left <= left - 16'd1;
                        if (left > 16'd1) begin
                            stb_o <= 1'b1;
                            state <= S_STROBE;
                        end else begin
                            state <= S_PUSH;
                        end
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                    S_PUSH: if (!fifo_full) state <= S_NEXT;
                    S_NEXT: if (sum > {1'b0, stop_r} || sum[CODE_W]) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        code  <= sum[CODE_W-1:0];
                        hits  <= '0;
                        left  <= samples_eff;
                        wcnt  <= '0;
                        state <= S_SETTLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef MU_SWEEP_IRQ_EN
    logic done_d, full_d, irq_clr;
    assign irq_clr = wr && (adr == 3'd0) && wb_dat_i[2];
    assign irq_bit = irq_o;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            irq_o  <= 1'b0;
            done_d <= 1'b0;
            full_d <= 1'b0;
        end else begin
            done_d <= done;
            full_d <= fifo_full;
            if ((done && !done_d) || (fifo_full && !full_d)) irq_o <= 1'b1;
            else if (irq_clr)                                irq_o <= 1'b0;
        end
    end
`else
    assign irq_bit = 1'b0;
`endif

endmodule

// File: tb/tb_mu_sweep_seq.sv
// Directed bench for mu_sweep_seq (FIFO depth 4); one task per scenario.
module tb_mu_sweep_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat_w = '0, wb_dat_r;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_ack, wb_stall, wb_err, stb, busy;
    logic        cmp = 1'b0;
    logic [9:0]  delay_code;
`ifdef MU_SWEEP_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad = 0;
    int stb_total = 0;
    int stb_wide = 0;
    logic stb_prev = 1'b0;

    mu_sweep_seq #(.FIFO_LG(2), .CMP_DLY(4), .CODE_W(10)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel),
        .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack), .wb_stall_o(wb_stall), .wb_err_o(wb_err),
        .delay_code_o(delay_code), .stb_o(stb), .cmp_i(cmp), .busy_o(busy)
`ifdef MU_SWEEP_IRQ_EN
        , .irq_o(irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stb) stb_total++;
        if (stb && stb_prev) stb_wide++;
        stb_prev = stb;
    end

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = {27'd0, a, 2'b00}; wb_dat_w = d;
        do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 20);
        total++;
        if (!wb_ack) begin bad++; $display("FAIL wb_write_ack: got timeout want ack adr=%0d", a); end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = {27'd0, a, 2'b00};
        do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 20);
        total++;
        if (!wb_ack) begin bad++; $display("FAIL wb_read_ack: got timeout want ack adr=%0d", a); end
        d = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (busy && n < 3000) begin @(posedge clk); #1; n++; end
        ok = !busy;
    endtask

    task automatic config_sweep(input logic [31:0] st, sp, step, smp, stl);
        wb_write(3'd1, st);
        wb_write(3'd2, sp);
        wb_write(3'd3, step);
        wb_write(3'd4, smp);
        wb_write(3'd5, stl);
    endtask

    task automatic test_reset;
        int adrs[7] = '{0, 1, 2, 3, 4, 5, 7};
        logic [31:0] exps[7] = '{32'h4, 32'h0, 32'h3FF, 32'h1, 32'h1, 32'h0, 32'h0};
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        total++;
        if ({wb_ack, wb_dat_r, stb, busy, delay_code} !== 45'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ack=%b dat=%h stb=%b busy=%b code=%h want all 0",
                     wb_ack, wb_dat_r, stb, busy, delay_code);
        end
        for (int i = 0; i < 7; i++) begin
            wb_read(3'(adrs[i]), d);
            if (adrs[i] == 0) d = d & 32'hF;
            total++;
            if (d !== exps[i]) begin
                bad++; $display("FAIL reset_reg%0d: got %h want %h", adrs[i], d, exps[i]);
            end
        end
    endtask

    task automatic test_basic_sweep;
        logic [31:0] d, e;
        bit ok;
        int base;
        cmp = 1'b1;
        config_sweep(10, 13, 1, 4, 0);
        base = stb_total;
        wb_write(3'd0, 32'h1);
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done: got busy want idle"); end
        total++;
        if (stb_total - base !== 16) begin
            bad++; $display("FAIL basic_stb_count: got %0d want 16", stb_total - base);
        end
        total++;
        if (delay_code !== 10'd13) begin
            bad++; $display("FAIL basic_code_hold: got %h want 00d", delay_code);
        end
        wb_read(3'd0, d);
        total++;
        if ((d & 32'hF) !== 32'hA) begin bad++; $display("FAIL basic_ctrl: got %h want a", d & 32'hF); end
        wb_read(3'd7, d);
        total++;
        if (d !== 32'd4) begin bad++; $display("FAIL basic_level: got %0d want 4", d); end
        for (int i = 0; i < 4; i++) begin
            wb_read(3'd6, d);
            e = 32'h8000_0004 | (32'(10 + i) << 16);
            total++;
            if (d !== e) begin bad++; $display("FAIL basic_result%0d: got %h want %h", i, d, e); end
        end
        wb_read(3'd6, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL empty_result: got %h want 0", d); end
        wb_read(3'd7, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL empty_level: got %0d want 0", d); end
    endtask

    task automatic test_step_wrap;
        logic [31:0] d;
        bit ok;
        int base;
        cmp = 1'b0;
        config_sweep(0, 32'h3FF, 32'h200, 1, 0);
        base = stb_total;
        wb_write(3'd0, 32'h1);
        wait_idle(ok);
        total++;
        if (!ok || stb_total - base !== 2) begin
            bad++; $display("FAIL wrap_stb_count: got %0d want 2", stb_total - base);
        end
        wb_read(3'd0, d);
        total++;
        if ((d & 32'hF) !== 32'h2) begin bad++; $display("FAIL wrap_ctrl: got %h want 2", d & 32'hF); end
        wb_read(3'd6, d);
        total++;
        if (d !== 32'h8000_0000) begin bad++; $display("FAIL wrap_result0: got %h want 80000000", d); end
        wb_read(3'd6, d);
        total++;
        if (d !== 32'h8200_0000) begin bad++; $display("FAIL wrap_result1: got %h want 82000000", d); end
        wb_read(3'd7, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL wrap_level: got %0d want 0", d); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        wb_read(3'd0, d);
`ifdef MU_SWEEP_IRQ_EN
        total++;
        if (irq !== 1'b1 || d[4] !== 1'b1) begin
            bad++; $display("FAIL irq_set: got irq=%b ctrl4=%b want 1", irq, d[4]);
        end
        wb_write(3'd0, 32'h4);
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
`else
        total++;
        if (d[4] !== 1'b0) begin bad++; $display("FAIL ctrl_b4: got %b want 0", d[4]); end
`endif
    endtask

    task automatic test_settle;
        logic [31:0] d;
        bit ok;
        int k = 0;
        int base;
        cmp = 1'b1;
        config_sweep(7, 7, 1, 0, 5);
        base = stb_total;
        wb_write(3'd0, 32'h1);
        do begin @(posedge clk); #1; k++; end while (!stb && k < 30);
        total++;
        if (k !== 7) begin bad++; $display("FAIL settle_latency: got %0d want 7", k); end
        wait_idle(ok);
        total++;
        if (!ok || stb_total - base !== 1) begin
            bad++; $display("FAIL samples0_strobes: got %0d want 1", stb_total - base);
        end
        wb_read(3'd6, d);
        total++;
        if (d !== 32'h8007_0001) begin bad++; $display("FAIL settle_result: got %h want 80070001", d); end
        wb_write(3'd5, 32'h0);
    endtask

    task automatic test_fifo_stall;
        logic [31:0] d, e;
        bit ok;
        int base;
        cmp = 1'b1;
        config_sweep(0, 5, 1, 1, 0);
        base = stb_total;
        wb_write(3'd0, 32'h1);
        repeat (150) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || stb_total - base !== 5 || delay_code !== 10'd4) begin
            bad++; $display("FAIL stall_state: got busy=%b stb=%0d code=%0d want 1 5 4",
                            busy, stb_total - base, delay_code);
        end
        wb_write(3'd0, 32'h1);
        wb_read(3'd7, d);
        total++;
        if (d !== 32'd4) begin bad++; $display("FAIL stall_level: got %0d want 4", d); end
        for (int i = 0; i < 2; i++) begin
            wb_read(3'd6, d);
            e = 32'h8000_0001 | (32'(i) << 16);
            total++;
            if (d !== e) begin bad++; $display("FAIL stall_pop%0d: got %h want %h", i, d, e); end
        end
        wait_idle(ok);
        wb_read(3'd7, d);
        total++;
        if (!ok || d !== 32'd4) begin bad++; $display("FAIL stall_resume_level: got %0d want 4", d); end
        for (int i = 2; i < 6; i++) begin
            wb_read(3'd6, d);
            e = 32'h8000_0001 | (32'(i) << 16);
            total++;
            if (d !== e) begin bad++; $display("FAIL stall_drain%0d: got %h want %h", i, d, e); end
        end
        wb_read(3'd0, d);
        total++;
        if ((d & 32'hF) !== 32'h6) begin bad++; $display("FAIL stall_ctrl: got %h want 6", d & 32'hF); end
    endtask

    task automatic test_abort;
        logic [31:0] d, e;
        int seen = 0;
        int n = 0;
        int base;
        cmp = 1'b1;
        config_sweep(0, 32'h3FF, 1, 1, 0);
        wb_write(3'd0, 32'h1);
        do begin @(posedge clk); #1; n++; if (stb) seen++; end while (seen < 3 && n < 200);
        @(posedge clk);
        wb_write(3'd0, 32'h2);
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        base = stb_total;
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (stb_total !== base || delay_code !== 10'd2) begin
            bad++; $display("FAIL abort_quiet: got stb=%0d code=%0d want 0 2", stb_total - base, delay_code);
        end
        wb_read(3'd0, d);
        total++;
        if ((d & 32'hF) !== 32'h0) begin bad++; $display("FAIL abort_ctrl: got %h want 0", d & 32'hF); end
        for (int i = 0; i < 2; i++) begin
            wb_read(3'd6, d);
            e = 32'h8000_0001 | (32'(i) << 16);
            total++;
            if (d !== e) begin bad++; $display("FAIL abort_result%0d: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_start_abort_same;
        int base = stb_total;
        wb_write(3'd0, 32'h3);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || stb_total !== base || delay_code !== 10'd2) begin
            bad++; $display("FAIL start_abort: got busy=%b stb=%0d code=%0d want 0 0 2",
                            busy, stb_total - base, delay_code);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        config_sweep(0, 32'h3FF, 1, 1, 0);
        wb_write(3'd2, 32'h100);
        wb_write(3'd0, 32'h1);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        total++;
        if (busy !== 1'b0 || stb !== 1'b0 || delay_code !== 10'd0 || wb_ack !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got busy=%b stb=%b code=%h ack=%b want 0", busy, stb, delay_code, wb_ack);
        end
        wb_read(3'd2, d);
        total++;
        if (d !== 32'h3FF) begin bad++; $display("FAIL reset_mid_stop: got %h want 3ff", d); end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_step_wrap();
        test_irq();
        test_settle();
        test_fifo_stall();
        test_abort();
        test_start_abort_same();
        test_reset_mid();
        total++;
        if (stb_wide !== 0) begin bad++; $display("FAIL stb_width: got %0d wide pulses want 0", stb_wide); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
